mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single 64-bit memory port between instruction fetch (IF) and data
//   access (D). Drives the 2-bit select of the 64-bit 2:1 port mux (00 = IF, 11 = D).
//   Latches the winner's request, holds the grant until the memory acks or times out,
//   and returns the ack/rdata to the winner.
//   Data has priority; a starvation counter guarantees IF progress.
// PARAMETERS
//   DATA_W        64  width of addr/wdata/rdata buses
//   STARVE_LIMIT  4   consecutive D grants with IF pending before IF is forced to win (>=1)
//   TIMEOUT       16  cycles in a grant state without mem_ack before abort (>=2)
// PORTS
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous reset, active low
//   if_req      in   1       IF read request; held high until if_ack or if_err
//   if_addr     in   DATA_W  IF address
//   if_ack      out  1       one-cycle pulse: IF transaction done, if_rdata valid this cycle
//   if_rdata    out  DATA_W  mem_rdata passthrough, valid with if_ack
//   d_req       in   1       data request; held high until d_ack or d_err
//   d_we        in   1       1 = write, 0 = read
//   d_addr      in   DATA_W  data address
//   d_wdata     in   DATA_W  write data
//   d_ack       out  1       one-cycle pulse: D transaction done
//   d_rdata     out  DATA_W  mem_rdata passthrough, valid with d_ack
//   if_err      out  1       one-cycle pulse: IF transaction timed out
//   d_err       out  1       one-cycle pulse: D transaction timed out
//   sel         out  2       port-mux select: 2'b00 = IF, 2'b11 = D (01/10 never driven)
//   mem_req     out  1       high for every cycle of a grant state
//   mem_we      out  1       latched d_we in GRANT_D, 0 otherwise
//   mem_addr    out  DATA_W  latched address of the granted requester
//   mem_wdata   out  DATA_W  latched d_wdata in GRANT_D, 0 otherwise
//   mem_rdata   in   DATA_W  memory read data, valid with mem_ack
//   mem_ack     in   1       memory completion, one cycle, only while mem_req = 1
// BEHAVIOUR
//   Reset (async, rst_n = 0):
//     - state = IDLE; sel = 00; mem_req/mem_we = 0; mem_addr/mem_wdata = 0.
//     - all acks/errs = 0; starvation counter = 0; timer = 0.
//     - an in-flight transaction is dropped without ack.
//   FSM states: IDLE, GRANT_IF, GRANT_D. All outputs except ack/err/rdata are registered.
//   IDLE, at clock edge:
//     - d_req & (!if_req | starve_cnt < STARVE_LIMIT) -> GRANT_D;
//       latch d_addr/d_we/d_wdata; sel <= 11.
//     - else if_req -> GRANT_IF; latch if_addr; sel <= 00.
//     - else stay; sel holds its last value.
//   Starvation counter:
//     - +1 on each D grant taken while if_req = 1 (saturates at STARVE_LIMIT).
//     - cleared on each IF grant, and when if_req = 0 in IDLE.
//   GRANT_x:
//     - mem_req = 1. Inputs from both requesters are ignored; the latched copy is used.
//     - mem_ack = 1: x_ack = mem_ack and x_rdata = mem_rdata, same cycle (combinational);
//       next state IDLE.
//     - Timer counts cycles in the grant state. When timer = TIMEOUT-1 and no mem_ack:
//       pulse x_err, next state IDLE.
//     - mem_ack in that same cycle wins: ack is given, no err.
//   Latency: req high at edge N -> mem_req from N+1; ack in the same cycle as mem_ack.
//     - One mandatory IDLE bubble between grants.
//     - Back-to-back single-cycle-memory throughput: 1 transaction per 2 cycles.
//   Protocol violations:
//     - Requester drops req mid-grant: transaction still completes; ack still pulses.
//     - mem_ack while IDLE is ignored.
//   Non-granted ack/rdata: ack = 0; rdata = 0.
// TESTING
//   1. Reset mid-GRANT_D (rst_n low 1 cycle) -> mem_req=0, sel=00, no d_ack, IDLE after release.
//   2. if_req only, if_addr=0x100, mem returns 0xDEAD after 3 cycles -> sel=00,
//      mem_addr=0x100, if_ack pulses once with if_rdata=0xDEAD.
//   3. if_req & d_req together, d_we=1, d_addr=0x200, d_wdata=2, mem_ack 1 cycle later
//      -> D granted first (sel=11, mem_we=1, mem_wdata=2), then IF after one IDLE cycle.
//   4. d_req held continuously with IF pending, STARVE_LIMIT=4 -> exactly 4 D grants,
//      then 1 IF grant, then counter restarts.
//   5. mem_ack never asserted, TIMEOUT=16 -> d_err pulses in the 16th grant cycle,
//      d_ack stays 0, FSM back in IDLE.
//   6. mem_ack on the timeout cycle -> ack=1, err=0. Also: sel only ever 00/11
//      (assert on every cycle).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between instruction fetch (IF) and data access (D).
//   D has priority; a starvation counter forces an IF grant after STARVE_LIMIT
//   consecutive D grants taken while IF was waiting. The winner's request is
//   latched, the grant is held until mem_ack or a timeout, and ack/rdata (or
//   err) are returned combinationally to the winner in the completing cycle.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req, if_addr            IF read request (held until if_ack/if_err)
//   if_ack, if_rdata, if_err   IF completion pulse, read data, timeout pulse
//   d_req, d_we, d_addr,
//   d_wdata                    D request (held until d_ack/d_err)
//   d_ack, d_rdata, d_err      D completion pulse, read data, timeout pulse
//   sel                        port-mux select, 2'b00 = IF, 2'b11 = D
//   mem_req, mem_we, mem_addr,
//   mem_wdata                  registered memory request
//   mem_rdata, mem_ack         memory response
//   dbg_state                  current FSM state (0 IDLE, 1 GRANT_IF, 2 GRANT_D)
//
// Handshake: a requester raises x_req and holds it with stable payload until
// x_ack or x_err pulses for one cycle. The payload is sampled only on the
// IDLE->GRANT edge, so changes to req/payload during a grant are ignored.
// Memory sees mem_req high for the whole grant; mem_ack is a single-cycle
// completion that is only honoured while mem_req is high.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              if_err,
  output logic              d_err,
  output logic [1:0]        sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        dbg_state
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_IF = 2'd1,
    ST_GRANT_D  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic in_grant_if, in_grant_d, timeout_hit;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= 2'b00;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      timer_q  <= timer_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    timer_d  = timer_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (d_req && (!if_req || (starve_q < STARVE_MAX))) begin
          state_d = ST_GRANT_D;
          sel_d   = 2'b11;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          // Only D grants that made IF wait count toward starvation.
          if (if_req) begin
            if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end else if (if_req) begin
          state_d  = ST_GRANT_IF;
          sel_d    = 2'b00;
          we_d     = 1'b0;
          addr_d   = if_addr;
          wdata_d  = '0;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end

      ST_GRANT_IF, ST_GRANT_D: begin
        // mem_ack on the last timer cycle completes normally (ack beats err).
        if (mem_ack || (timer_q == TIMER_LAST)) begin
          state_d = ST_IDLE;
          we_d    = 1'b0;
          wdata_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
        wdata_d = '0;
        timer_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_grant_if = (state_q == ST_GRANT_IF);
  assign in_grant_d  = (state_q == ST_GRANT_D);
  assign timeout_hit = (timer_q == TIMER_LAST) && !mem_ack;

  assign if_ack   = in_grant_if && mem_ack;
  assign d_ack    = in_grant_d && mem_ack;
  assign if_err   = in_grant_if && timeout_hit;
  assign d_err    = in_grant_d && timeout_hit;
  assign if_rdata = if_ack ? mem_rdata : '0;
  assign d_rdata  = d_ack ? mem_rdata : '0;

  assign sel       = sel_q;
  assign mem_req   = in_grant_if || in_grant_d;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (DATA_W=64, STARVE_LIMIT=4,
//   TIMEOUT=16). Inputs change 1 ns after the rising edge; outputs are checked
//   1 ns after any input change, plus a sel legality check on every falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int DATA_W = 64;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GIF  = 2'd1;
  localparam logic [1:0] S_GD   = 2'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              if_req, d_req, d_we, mem_ack;
  logic [DATA_W-1:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic              if_ack, d_ack, if_err, d_err, mem_req, mem_we;
  logic [DATA_W-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]        sel, dbg_state;

  mem_port_arbiter #(.DATA_W(64), .STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .if_err(if_err), .d_err(d_err),
    .sel(sel), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_bad   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // sel must never show 01 or 10.
  always @(negedge clk) begin
    check("sel_legal", {63'd0, (sel == 2'b01) || (sel == 2'b10)}, 64'd0);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();

    // Reset state
    check("rst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
    check("rst_sel", {62'd0, sel}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1. Reset while in GRANT_D
    d_req = 1; d_we = 1; d_addr = 64'h300; d_wdata = 64'h9;
    tick();
    check("t1_granted", {62'd0, dbg_state}, {62'd0, S_GD});
    check("t1_sel_d", {62'd0, sel}, 64'd3);
    rst_n = 1'b0; mem_ack = 1; mem_rdata = 64'h1;
    settle();
    check("t1_rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("t1_rst_sel", {62'd0, sel}, 64'd0);
    check("t1_rst_d_ack", {63'd0, d_ack}, 64'd0);
    check("t1_rst_mem_we", {63'd0, mem_we}, 64'd0);
    tick();
    rst_n = 1'b1; d_req = 0; mem_ack = 0;
    settle();
    check("t1_idle_after", {62'd0, dbg_state}, {62'd0, S_IDLE});

    // mem_ack while IDLE is ignored
    mem_ack = 1; mem_rdata = 64'hBAD;
    settle();
    check("idle_ack_if", {63'd0, if_ack}, 64'd0);
    check("idle_ack_d", {63'd0, d_ack}, 64'd0);
    check("idle_rdata_d", d_rdata, 64'd0);
    tick();
    mem_ack = 0;
    check("idle_stays", {62'd0, dbg_state}, {62'd0, S_IDLE});

    // 2. IF only, memory answers in 3rd grant cycle
    if_req = 1; if_addr = 64'h100;
    tick();
    check("t2_sel", {62'd0, sel}, 64'd0);
    check("t2_addr", mem_addr, 64'h100);
    check("t2_mem_req", {63'd0, mem_req}, 64'd1);
    check("t2_ack_c1", {63'd0, if_ack}, 64'd0);
    tick();
    check("t2_ack_c2", {63'd0, if_ack}, 64'd0);
    tick();
    mem_ack = 1; mem_rdata = 64'hDEAD;
    settle();
    check("t2_ack_c3", {63'd0, if_ack}, 64'd1);
    check("t2_rdata", if_rdata, 64'hDEAD);
    check("t2_d_ack", {63'd0, d_ack}, 64'd0);
    check("t2_d_rdata", d_rdata, 64'd0);
    tick();
    mem_ack = 0; if_req = 0;
    settle();
    check("t2_ack_after", {63'd0, if_ack}, 64'd0);
    check("t2_idle", {62'd0, dbg_state}, {62'd0, S_IDLE});
    check("t2_mem_req_off", {63'd0, mem_req}, 64'd0);

    // 3. Simultaneous requests: D first, then IF after one IDLE cycle
    if_req = 1; if_addr = 64'h180;
    d_req = 1; d_we = 1; d_addr = 64'h200; d_wdata = 64'h2;
    tick();
    check("t3_d_sel", {62'd0, sel}, 64'd3);
    check("t3_d_we", {63'd0, mem_we}, 64'd1);
    check("t3_d_wdata", mem_wdata, 64'h2);
    check("t3_d_addr", mem_addr, 64'h200);
    mem_ack = 1; mem_rdata = 64'h55;
    settle();
    check("t3_d_ack", {63'd0, d_ack}, 64'd1);
    check("t3_if_ack_off", {63'd0, if_ack}, 64'd0);
    check("t3_if_rdata_off", if_rdata, 64'd0);
    tick();
    mem_ack = 0; d_req = 0;
    check("t3_bubble", {62'd0, dbg_state}, {62'd0, S_IDLE});
    check("t3_bubble_req", {63'd0, mem_req}, 64'd0);
    check("t3_bubble_we", {63'd0, mem_we}, 64'd0);
    check("t3_sel_hold", {62'd0, sel}, 64'd3);
    tick();
    check("t3_if_sel", {62'd0, sel}, 64'd0);
    check("t3_if_addr", mem_addr, 64'h180);
    check("t3_if_wdata", mem_wdata, 64'd0);
    mem_ack = 1; mem_rdata = 64'h77;
    settle();
    check("t3_if_ack", {63'd0, if_ack}, 64'd1);
    check("t3_if_rdata", if_rdata, 64'h77);
    tick();
    mem_ack = 0; if_req = 0;

    // 4. Starvation: both held, expect D D D D IF D D D D IF
    for (int i = 0; i < 10; i++) exp_q.push_back((i % 5 == 4) ? S_GIF : S_GD);
    if_req = 1; if_addr = 64'h1000; d_req = 1; d_we = 0; d_addr = 64'h2000;
    for (int i = 0; i < 10; i++) begin
      logic [1:0] e;
      tick();
      e = exp_q.pop_front();
      check("t4_winner", {62'd0, dbg_state}, {62'd0, e});
      mem_ack = 1; mem_rdata = 64'(i);
      settle();
      if (e == S_GIF) check("t4_if_ack", {63'd0, if_ack}, 64'd1);
      else            check("t4_d_ack", {63'd0, d_ack}, 64'd1);
      tick();
      mem_ack = 0;
    end
    if_req = 0; d_req = 0;
    tick();

    // 5. Timeout on D: err in the 16th grant cycle
    d_req = 1; d_we = 0; d_addr = 64'h400;
    tick();
    for (int c = 1; c <= 16; c++) begin
      check("t5_d_err", {63'd0, d_err}, {63'd0, c == 16});
      check("t5_d_ack", {63'd0, d_ack}, 64'd0);
      check("t5_mem_req", {63'd0, mem_req}, 64'd1);
      if (c < 16) tick();
    end
    d_req = 0;
    tick();
    check("t5_idle", {62'd0, dbg_state}, {62'd0, S_IDLE});
    check("t5_err_off", {63'd0, d_err}, 64'd0);

    // 6. mem_ack on the timeout cycle wins over err (IF side)
    if_req = 1; if_addr = 64'h500;
    tick();
    for (int c = 1; c < 16; c++) begin
      if (c == 15) check("t6_no_err_c15", {63'd0, if_err}, 64'd0);
      tick();
    end
    mem_ack = 1; mem_rdata = 64'hABC;
    settle();
    check("t6_ack", {63'd0, if_ack}, 64'd1);
    check("t6_err", {63'd0, if_err}, 64'd0);
    check("t6_rdata", if_rdata, 64'hABC);
    tick();
    mem_ack = 0; if_req = 0;
    check("t6_idle", {62'd0, dbg_state}, {62'd0, S_IDLE});
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
